// File: rtl/delay_pipe_ctrl.sv
// Ready/valid flow control around a fixed-latency en-gated pipeline.
// Optional DELAY_PIPE_CTRL_STATS_EN adds stat_in/stat_out/stat_stall counters.
module delay_pipe_ctrl #(
  parameter int LATENCY = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         pipe_en,
  output logic [WIDTH-1:0]             pipe_in,
  input  logic [WIDTH-1:0]             pipe_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(LATENCY+1)-1:0] inflight,
`ifdef DELAY_PIPE_CTRL_STATS_EN
  output logic [31:0]                  stat_in,
  output logic [31:0]                  stat_out,
  output logic [31:0]                  stat_stall,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int IW = $clog2(LATENCY+1);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (LATENCY < 1) begin : g_bad_latency
    $error("delay_pipe_ctrl: LATENCY must be >= 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("delay_pipe_ctrl: DEPTH must be >= 1");
  end

  logic [LATENCY-1:0] vld;
  logic [LATENCY:0]   sh;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               fifo_full;
  logic               accept;
  logic               wr;
  logic               rd;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Stall only when the last stage holds an item the FIFO cannot take.
  assign fifo_full = (fifo_count == CW'(DEPTH));
  assign pipe_en   = flush | ~vld[LATENCY-1] | ~fifo_full;
  assign in_ready  = pipe_en & ~flush;
  assign accept    = in_valid & in_ready;
  assign pipe_in   = in_data;
  assign sh        = {vld, accept};
  assign wr        = pipe_en & vld[LATENCY-1] & ~flush;
  assign rd        = out_valid & out_ready & ~flush;
  assign out_valid = (fifo_count != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld      <= '0;
      inflight <= '0;
    end else if (flush) begin
      vld      <= '0;
      inflight <= '0;
    end else if (pipe_en) begin
      vld      <= sh[LATENCY-1:0];
      inflight <= inflight + IW'(accept) - IW'(vld[LATENCY-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= pipe_out;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (rd) rd_ptr <= nxt(rd_ptr);
      fifo_count <= fifo_count + CW'(wr) - CW'(rd);
    end
  end

`ifdef DELAY_PIPE_CTRL_STATS_EN
  logic stall;
  assign stall = in_valid & ~in_ready;

  // Saturating; flush deliberately leaves history intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_in    <= '0;
      stat_out   <= '0;
      stat_stall <= '0;
    end else begin
      if (accept && stat_in != '1)    stat_in    <= stat_in + 32'd1;
      if (rd && stat_out != '1)       stat_out   <= stat_out + 32'd1;
      if (stall && stat_stall != '1)  stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_delay_pipe_ctrl.sv
// Scoreboard bench for delay_pipe_ctrl with an en-gated pipeline model.
// Stats checks compile in when DELAY_PIPE_CTRL_STATS_EN is defined.
module tb_delay_pipe_ctrl;

  localparam int L = 4;
  localparam int D = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, pipe_en, out_valid;
  logic [W-1:0] pipe_in, pipe_out, out_data;
  logic [$clog2(L+1)-1:0] inflight;
  logic [$clog2(D+1)-1:0] fifo_count;
`ifdef DELAY_PIPE_CTRL_STATS_EN
  logic [31:0] stat_in, stat_out, stat_stall;
`endif

  always #5 clk = ~clk;

  delay_pipe_ctrl #(.LATENCY(L), .WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .pipe_en(pipe_en), .pipe_in(pipe_in), .pipe_out(pipe_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .inflight(inflight),
`ifdef DELAY_PIPE_CTRL_STATS_EN
    .stat_in(stat_in), .stat_out(stat_out), .stat_stall(stat_stall),
`endif
    .fifo_count(fifo_count)
  );

  // Controlled pipeline: L en-gated stages.
  logic [W-1:0] stg [L];
  always @(posedge clk) begin
    if (pipe_en) begin
      stg[0] <= pipe_in;
      for (int i = 1; i < L; i++) stg[i] <= stg[i-1];
    end
  end
  assign pipe_out = stg[L-1];

  int errors = 0;
  int checks = 0;
  int n_out = 0;
  logic [W-1:0] q [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected items: everything accepted and not yet consumed, in order.
  always @(negedge clk) begin
    #1;
    if (!rst_n || flush) q.delete();
    else if (in_valid && in_ready) q.push_back(in_data);
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && !flush && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_item: got %0h expected none", out_data);
      end else begin
        chk("out_data", out_data, q.pop_front());
        n_out++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("occupancy", inflight + fifo_count, q.size());
      chk("capacity", q.size() <= L + D, 1);
    end
  end

  task automatic wait_empty(input string name);
    int k = 0;
    while (!(q.size() == 0 && fifo_count == 0 && inflight == 0) && k < 100) begin
      @(negedge clk);
      #3;
      k++;
    end
    checks++;
    if (k >= 100) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d items left", name, q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int acc, stalls, first_ov, base_out;
`ifdef DELAY_PIPE_CTRL_STATS_EN
  logic [31:0] b_in, b_out, b_st;
`endif

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_fifo_count", fifo_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream with no backpressure
    out_ready = 1'b1;
    first_ov = -1;
    base_out = n_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = W'(i);
      #1;
      chk("stream_in_ready", in_ready, 1);
      if (out_valid && first_ov < 0) first_ov = i;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_empty("stream");
    chk("stream_latency", first_ov, L + 1);
    chk("stream_count", n_out - base_out, 10);

    // Backpressure: only L+D items fit
`ifdef DELAY_PIPE_CTRL_STATS_EN
    b_in = stat_in; b_out = stat_out; b_st = stat_stall;
`endif
    out_ready = 1'b0;
    acc = 0;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = W'(100 + i);
      #1;
      if (in_ready) acc++;
      else stalls++;
    end
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_accepted", acc, L + D);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
`ifdef DELAY_PIPE_CTRL_STATS_EN
    chk("stat_in", stat_in - b_in, L + D);
    chk("stat_stall", stat_stall - b_st, stalls);
`endif

    // Full boundary: one read frees a slot, refilled the cycle after
    chk("full_pipe_en", pipe_en, 0);
    chk("full_count", fifo_count, D);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("pulse_count", fifo_count, D - 1);
    chk("pulse_pipe_en", pipe_en, 1);
    @(negedge clk);
    #1;
    chk("refill_count", fifo_count, D);
    out_ready = 1'b1;
    wait_empty("bp_drain");
`ifdef DELAY_PIPE_CTRL_STATS_EN
    chk("stat_out", stat_out - b_out, L + D);
`endif

    // Asynchronous reset with three items in flight
    base_out = n_out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = W'(200 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_inflight", inflight, 3);
    rst_n = 1'b0;
    #1;
    chk("arst_inflight", inflight, 0);
    chk("arst_fifo_count", fifo_count, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("arst_none_out", n_out - base_out, 0);

    // Flush with 3 in flight and 2 buffered
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = W'(300 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = W'(310 + i);
    end
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 32'hdead;
    #1;
    chk("pre_flush_inflight", inflight, 3);
    chk("pre_flush_count", fifo_count, 2);
    base_out = n_out;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_inflight", inflight, 0);
    chk("flush_count", fifo_count, 0);
    chk("flush_out_valid", out_valid, 0);
    repeat (15) @(negedge clk);
    chk("flush_none_out", n_out - base_out, 0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1) == 1;
      flush = ($urandom_range(0, 63) == 0);
      in_data = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    wait_empty("random_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
